// File: rtl/freq_pkg.sv
// Shared state encoding and width helper for the frequency measurement sequencer.
package freq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        FILL  = 2'd2,
        RUN   = 2'd3
    } state_t;

    // Counter/result width for a count range of n; never narrower than one bit.
    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/edge_sync.sv
// Multi-flop synchronizer for an asynchronous pin followed by a registered
// rising-edge detector producing one-cycle pulses.
module edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic sig_i,
    output logic pulse_o
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   hist_q, hist_d;
    logic                   pulse_q, pulse_d;

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], sig_i};
        hist_d  = sync_q[SYNC_STAGES-1];
        pulse_d = sync_q[SYNC_STAGES-1] & ~hist_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q  <= '0;
            hist_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            hist_q  <= hist_d;
            pulse_q <= pulse_d;
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/freq_meas_ctrl.sv
// Sequencer for the moving-average frequency datapath: clear, fill, then periodic
// result publishing. Define FREQ_PEAK_HOLD_EN to add the peak-hold output.
module freq_meas_ctrl
    import freq_pkg::*;
#(
    parameter int  DEPTH       = 1000,
    parameter int  UPDATE      = 250,
    parameter int  SYNC_STAGES = 2,
    localparam int AW          = width_of(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en_i,
`ifdef FREQ_PEAK_HOLD_EN
    input  logic          peak_clr_i,
    output logic [AW-1:0] peak_o,
`endif
    input  logic          sig_i,
    input  logic [AW-1:0] avg_i,
    output logic          dp_reset_o,
    output logic          sample_o,
    output logic [AW-1:0] result_o,
    output logic          valid_o,
    output logic          busy_o
);

    localparam int WW = width_of(DEPTH);
    localparam int UW = $clog2(UPDATE) + 1;

    state_t          state_q, state_d;
    logic [WW-1:0]   win_q, win_d;
    logic [UW-1:0]   upd_q, upd_d;
    logic [AW-1:0]   result_q, result_d;
    logic            valid_q, valid_d;
    logic            dp_reset_q, dp_reset_d;
    logic            busy_q, busy_d;
    logic            publish;
    logic            pulse;

    edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_edge_sync (
        .clk    (clk),
        .reset  (reset),
        .sig_i  (sig_i),
        .pulse_o(pulse)
    );

    always_comb begin
        state_d  = state_q;
        win_d    = win_q;
        upd_d    = upd_q;
        result_d = result_q;
        valid_d  = valid_q;
        publish  = 1'b0;
        case (state_q)
            IDLE: begin
                if (en_i) state_d = CLEAR;
            end
            CLEAR: begin
                state_d = FILL;
                win_d   = '0;
                valid_d = 1'b0;
            end
            FILL: begin
                win_d = win_q + WW'(1);
                if (win_q == WW'(DEPTH - 1)) begin
                    state_d = RUN;
                    upd_d   = '0;
                end
            end
            RUN: begin
                // Count zero marks both the first RUN cycle and every wrap.
                publish = (upd_q == '0);
                upd_d   = (upd_q == UW'(UPDATE - 1)) ? '0 : upd_q + UW'(1);
                if (publish) begin
                    result_d = avg_i;
                    valid_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (!en_i && state_q != IDLE) begin
            state_d  = IDLE;
            valid_d  = 1'b0;
            result_d = result_q;
            publish  = 1'b0;
        end
        dp_reset_d = (state_d == IDLE) || (state_d == CLEAR);
        busy_d     = (state_d == CLEAR) || (state_d == FILL);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            win_q      <= '0;
            upd_q      <= '0;
            result_q   <= '0;
            valid_q    <= 1'b0;
            dp_reset_q <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            win_q      <= win_d;
            upd_q      <= upd_d;
            result_q   <= result_d;
            valid_q    <= valid_d;
            dp_reset_q <= dp_reset_d;
            busy_q     <= busy_d;
        end
    end

`ifdef FREQ_PEAK_HOLD_EN
    logic [AW-1:0] peak_q, peak_d;

    // A clear in the same cycle as a publish takes priority.
    always_comb begin
        peak_d = peak_q;
        if (peak_clr_i)
            peak_d = '0;
        else if (publish && avg_i > peak_q)
            peak_d = avg_i;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) peak_q <= '0;
        else        peak_q <= peak_d;
    end

    assign peak_o = peak_q;
`endif

    assign sample_o   = pulse & ((state_q == FILL) || (state_q == RUN));
    assign result_o   = result_q;
    assign valid_o    = valid_q;
    assign dp_reset_o = dp_reset_q;
    assign busy_o     = busy_q;

endmodule

// File: doc/freq_meas_ctrl.md
Name: freq_meas_ctrl

Overview:
- Sequencer for the moving-average frequency datapath.
- Synchronizes the external signal and converts its rising edges into a one-cycle sample stream for the moving average.
- Clears the datapath on start, suppresses results until the averaging window is full, then publishes a latched result every UPDATE cycles with a valid flag.
- Sits between the pin input, the moving-average instance and the output/readout logic.

Parameters:
- DEPTH, 1000, averaging window length in clk cycles; must match the datapath instance.
- UPDATE, 250, result publish period in clk cycles once running; 1..2^16.
- SYNC_STAGES, 2, synchronizer flops on sig_i; 2..4.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- en_i  in  1  measurement enable; level-sensitive
- sig_i  in  1  asynchronous signal under measurement
- avg_i  in  AW  running count from moving average, AW = $clog2(DEPTH)
- dp_reset_o  out  1  synchronous active-high clear to datapath
- sample_o  out  1  one-cycle pulse per synchronized rising edge; drives datapath data_i
- result_o  out  AW  latched edge count over last DEPTH cycles
- valid_o  out  1  result_o holds a full-window value
- busy_o  out  1  high in CLEAR or FILL

Behaviour:
- Reset asserted (reset=0): all flops cleared asynchronously.
  - State = IDLE; dp_reset_o=1; sample_o=0; result_o=0; valid_o=0; busy_o=0; synchronizer chain=0.
- Synchronizer: SYNC_STAGES flops plus one history flop.
  - sample_o = sync & ~hist, registered, so there is one extra cycle after the last sync stage.
  - sample_o is forced 0 outside FILL/RUN.
- FSM states:
  - IDLE:
    - dp_reset_o=1.
    - en_i=1 -> CLEAR.
  - CLEAR:
    - Exactly 1 cycle; dp_reset_o=1; window counter loaded with 0; result_o retained; valid_o=0.
    - Next state is FILL.
  - FILL:
    - dp_reset_o=0; sample_o live; window counter increments each cycle.
    - When the counter reaches DEPTH-1 -> RUN. This means DEPTH cycles of samples have entered the datapath.
  - RUN:
    - Update counter counts 0..UPDATE-1.
    - On the first RUN cycle and on each counter wrap, result_o <= avg_i and valid_o <= 1.
    - avg_i is sampled that cycle; it reflects samples up to the previous cycle.
- en_i=0 in any non-IDLE state -> IDLE next cycle.
  - result_o is held; valid_o cleared; dp_reset_o=1 from the next cycle.
- en_i re-asserted in IDLE -> full CLEAR/FILL sequence again; no partial resume.
- Asynchronous reset in any state aborts immediately; all outputs return to reset values.
- busy_o = (state==CLEAR) | (state==FILL).
- Width rules:
  - Window counter width is $clog2(DEPTH); update counter width is $clog2(UPDATE)+1.
  - No result_o saturation is needed: sample_o can be high at most every other cycle, so avg_i never exceeds ceil(DEPTH/2).

Optional Feature:
- Macro FREQ_PEAK_HOLD_EN.
- Defined:
  - Adds output peak_o [AW] and input peak_clr_i [1].
  - peak_o <= max(peak_o, avg_i) on every result publish.
  - peak_clr_i=1 zeroes peak_o next cycle. If a publish happens in the same cycle, the clear wins and peak_o=0.
  - peak_o resets to 0 and is held in IDLE.
- Undefined:
  - peak_o and peak_clr_i are absent.
  - No extra flops.

Decomposition:
- Package freq_pkg:
  - state encoding localparams IDLE=2'd0, CLEAR=2'd1, FILL=2'd2, RUN=2'd3;
  - shared width function/localparam AW=$clog2(DEPTH) helper.
- Sub-module edge_sync: SYNC_STAGES synchronizer plus rising-edge detect, producing the registered pulse.
- The FSM and counters stay in freq_meas_ctrl.

Test Plan:
- Reset release with en_i=0:
  - dp_reset_o=1, valid_o=0, result_o=0, sample_o=0 indefinitely.
  - Toggling sig_i gives no sample_o.
- DEPTH=16, UPDATE=4; en_i rises; sig_i square wave with period 4 clk:
  - CLEAR lasts 1 cycle, FILL 16 cycles, busy_o high for 17 cycles.
  - valid_o rises on the first RUN cycle; result_o=4 and is republished every 4 cycles.
- Single pulse on sig_i during FILL:
  - sample_o pulses exactly once, SYNC_STAGES+1 cycles after the synchronous edge.
  - No pulse for a sig_i high level held across multiple cycles.
- en_i dropped mid-RUN, with result_o=4:
  - Next cycle state=IDLE, valid_o=0, result_o stays 4, dp_reset_o=1.
  - Re-enable repeats CLEAR then 16 FILL cycles before valid_o.
- Async reset asserted mid-FILL, between clock edges:
  - Outputs go to reset values immediately, without waiting for a clk edge.
  - After release, the block stays in IDLE until en_i.
- With FREQ_PEAK_HOLD_EN, input sig_i period 4 then period 8:
  - peak_o=4 persists after result_o falls to 2.
  - peak_clr_i coincident with a publish gives peak_o=0.
